// File: rtl/sprite_animator.sv
// sprite_animator: single-sprite producer for the graphics block.
// Accepts a spawn command, walks the sprite toward its target, then loops
// the attack animation until killed. Visible sprite state only changes on
// new_frame pulses, so a frame is never drawn with mixed state.
module sprite_animator #(
    parameter int NUM_FRAMES  = 23,
    parameter int WALK_FRAMES = 12,
    parameter int FRAME_DIV   = 4,
    parameter int SPEED       = 2,
    parameter int SCREEN_W    = 1280,
    parameter int SCREEN_H    = 720
) (
    input  logic                          clk_pixel,
    input  logic                          sys_rst_n,
    input  logic                          new_frame,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [10:0]                   cmd_spawn_x,
    input  logic [9:0]                    cmd_spawn_y,
    input  logic [10:0]                   cmd_target_x,
    input  logic [9:0]                    cmd_target_y,
    input  logic                          kill,
    output logic                          sprite_valid,
    output logic [10:0]                   sprite_x,
    output logic [9:0]                    sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0] sprite_frame_number,
    output logic                          arrived
);

    localparam int FW    = $clog2(NUM_FRAMES);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [FW-1:0]    WALK_LAST  = FW'(WALK_FRAMES - 1);
    localparam logic [FW-1:0]    ATK_FIRST  = FW'(WALK_FRAMES);
    localparam logic [FW-1:0]    ATK_LAST   = FW'(NUM_FRAMES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [10:0]      X_MAX      = 11'(SCREEN_W - 1);
    localparam logic [9:0]       Y_MAX      = 10'(SCREEN_H - 1);
    localparam logic signed [11:0] STEP     = 12'(SPEED);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WALK,
        S_ATTACK
    } state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               valid_q;
    logic               arrived_q;
    logic               kill_pending_q;
    logic [10:0]        x_q;
    logic [9:0]         y_q;
    logic [FW-1:0]      frame_q;
    logic [DIV_W-1:0]   div_q;

    // Latched command (data only, no reset needed: only read after a command)
    logic [10:0]        spawn_x_q;
    logic [9:0]         spawn_y_q;
    logic [10:0]        tgt_x_q;
    logic [9:0]         tgt_y_q;

    // Next walking position for the current frame
    logic [10:0]        x_d;
    logic [9:0]         y_d;

    logic               accept;

    function automatic logic [10:0] clamp_x(input logic [10:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    // Differences are taken in 12-bit signed space so neither direction wraps;
    // a step within SPEED of the target snaps to it, so no overshoot either.
    function automatic logic [10:0] step_x(input logic [10:0] pos, input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        if (diff <= STEP && diff >= -STEP) return tgt;
        if (diff > 12'sd0) return pos + 11'(SPEED);
        return pos - 11'(SPEED);
    endfunction

    function automatic logic [9:0] step_y(input logic [9:0] pos, input logic [9:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({2'b00, tgt}) - $signed({2'b00, pos});
        if (diff <= STEP && diff >= -STEP) return tgt;
        if (diff > 12'sd0) return pos + 10'(SPEED);
        return pos - 10'(SPEED);
    endfunction

    function automatic logic [FW-1:0] next_walk_frame(input logic [FW-1:0] f);
        return (f == WALK_LAST) ? '0 : f + FW'(1);
    endfunction

    function automatic logic [FW-1:0] next_attack_frame(input logic [FW-1:0] f);
        return (f == ATK_LAST) ? ATK_FIRST : f + FW'(1);
    endfunction

    assign accept = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

    // Candidate position after one walking step
    always_comb begin
        x_d = step_x(x_q, tgt_x_q);
        y_d = step_y(y_q, tgt_y_q);
    end

    // Capture the clamped spawn/target on command acceptance
    always_ff @(posedge clk_pixel) begin
        if (accept) begin
            spawn_x_q <= clamp_x(cmd_spawn_x);
            spawn_y_q <= clamp_y(cmd_spawn_y);
            tgt_x_q   <= clamp_x(cmd_target_x);
            tgt_y_q   <= clamp_y(cmd_target_y);
        end
    end

    // Control FSM with registered outputs; sprite state moves only on new_frame
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            cmd_ready_q    <= 1'b1;
            valid_q        <= 1'b0;
            arrived_q      <= 1'b0;
            kill_pending_q <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            frame_q        <= '0;
            div_q          <= '0;
        end else begin
            arrived_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_ARMED;
                        cmd_ready_q <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (kill) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else if (new_frame) begin
                        x_q     <= spawn_x_q;
                        y_q     <= spawn_y_q;
                        div_q   <= '0;
                        valid_q <= 1'b1;
                        if (spawn_x_q == tgt_x_q && spawn_y_q == tgt_y_q) begin
                            state_q   <= S_ATTACK;
                            frame_q   <= ATK_FIRST;
                            arrived_q <= 1'b1;
                        end else begin
                            state_q <= S_WALK;
                            frame_q <= '0;
                        end
                    end
                end
                S_WALK, S_ATTACK: begin
                    if (kill) kill_pending_q <= 1'b1;
                    if (new_frame) begin
                        if (kill || kill_pending_q) begin
                            valid_q        <= 1'b0;
                            state_q        <= S_IDLE;
                            kill_pending_q <= 1'b0;
                            cmd_ready_q    <= 1'b1;
                        end else if (state_q == S_WALK &&
                                     x_d == tgt_x_q && y_d == tgt_y_q) begin
                            x_q       <= x_d;
                            y_q       <= y_d;
                            state_q   <= S_ATTACK;
                            frame_q   <= ATK_FIRST;
                            div_q     <= '0;
                            arrived_q <= 1'b1;
                        end else begin
                            if (state_q == S_WALK) begin
                                x_q <= x_d;
                                y_q <= y_d;
                            end
                            if (div_q == DIV_LAST) begin
                                div_q   <= '0;
                                frame_q <= (state_q == S_WALK) ? next_walk_frame(frame_q)
                                                               : next_attack_frame(frame_q);
                            end else begin
                                div_q <= div_q + DIV_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign sprite_valid        = valid_q;
    assign sprite_x            = x_q;
    assign sprite_y            = y_q;
    assign sprite_frame_number = frame_q;
    assign arrived             = arrived_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the sprite.
module tb_sprite_animator;

    localparam int NF = 23;
    localparam int WF = 12;
    localparam int FD = 4;
    localparam int SP = 2;
    localparam int SW = 1280;
    localparam int SH = 720;

    logic        clk_pixel = 1'b0;
    logic        sys_rst_n;
    logic        new_frame;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_spawn_x;
    logic [9:0]  cmd_spawn_y;
    logic [10:0] cmd_target_x;
    logic [9:0]  cmd_target_y;
    logic        kill;
    logic        sprite_valid;
    logic [10:0] sprite_x;
    logic [9:0]  sprite_y;
    logic [$clog2(NF)-1:0] sprite_frame_number;
    logic        arrived;

    always #5 clk_pixel = ~clk_pixel;

    sprite_animator #(
        .NUM_FRAMES(NF), .WALK_FRAMES(WF), .FRAME_DIV(FD),
        .SPEED(SP), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk_pixel(clk_pixel),
        .sys_rst_n(sys_rst_n),
        .new_frame(new_frame),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_spawn_x(cmd_spawn_x),
        .cmd_spawn_y(cmd_spawn_y),
        .cmd_target_x(cmd_target_x),
        .cmd_target_y(cmd_target_y),
        .kill(kill),
        .sprite_valid(sprite_valid),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
        .sprite_frame_number(sprite_frame_number),
        .arrived(arrived)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_WALK = 2, M_ATTACK = 3;
    int m_mode, m_valid, m_x, m_y, m_frame, m_arrived, m_ready, m_kp, m_cnt;
    int m_sx, m_sy, m_tx, m_ty;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int approach(input int p, input int t);
        int d;
        d = t - p;
        if (d <= SP && d >= -SP) return t;
        return (d > 0) ? p + SP : p - SP;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_valid = 0; m_x = 0; m_y = 0; m_frame = 0;
        m_arrived = 0; m_ready = 1; m_kp = 0; m_cnt = 0;
    endtask

    // One clock edge of sprite behaviour; m_cnt counts new_frame pulses
    // spent in the current animation so the frame is a plain division.
    task automatic model_update();
        m_arrived = 0;
        case (m_mode)
            M_IDLE: begin
                if (cmd_valid && m_ready == 1) begin
                    m_sx = clampi(int'(cmd_spawn_x), SW - 1);
                    m_sy = clampi(int'(cmd_spawn_y), SH - 1);
                    m_tx = clampi(int'(cmd_target_x), SW - 1);
                    m_ty = clampi(int'(cmd_target_y), SH - 1);
                    m_mode = M_ARMED;
                    m_ready = 0;
                end
            end
            M_ARMED: begin
                if (kill) begin
                    m_mode = M_IDLE;
                    m_ready = 1;
                end else if (new_frame) begin
                    m_x = m_sx; m_y = m_sy; m_valid = 1; m_cnt = 0;
                    if (m_sx == m_tx && m_sy == m_ty) begin
                        m_mode = M_ATTACK; m_frame = WF; m_arrived = 1;
                    end else begin
                        m_mode = M_WALK; m_frame = 0;
                    end
                end
            end
            default: begin
                if (new_frame && (kill || m_kp == 1)) begin
                    m_valid = 0; m_mode = M_IDLE; m_kp = 0; m_ready = 1;
                end else begin
                    if (kill) m_kp = 1;
                    if (new_frame) begin
                        if (m_mode == M_WALK) begin
                            m_x = approach(m_x, m_tx);
                            m_y = approach(m_y, m_ty);
                            if (m_x == m_tx && m_y == m_ty) begin
                                m_mode = M_ATTACK; m_cnt = 0; m_frame = WF; m_arrived = 1;
                            end else begin
                                m_cnt++;
                                m_frame = (m_cnt / FD) % WF;
                            end
                        end else begin
                            m_cnt++;
                            m_frame = WF + (m_cnt / FD) % (NF - WF);
                        end
                    end
                end
            end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input string tag);
        @(posedge clk_pixel);
        if (!sys_rst_n) model_reset(); else model_update();
        #1;
        chk({tag, ".valid"},   sprite_valid, m_valid);
        chk({tag, ".x"},       sprite_x, m_x);
        chk({tag, ".y"},       sprite_y, m_y);
        chk({tag, ".frame"},   sprite_frame_number, m_frame);
        chk({tag, ".arrived"}, arrived, m_arrived);
        chk({tag, ".ready"},   cmd_ready, m_ready);
    endtask

    task automatic pulse_nf(input string tag);
        new_frame = 1'b1;
        tick(tag);
        new_frame = 1'b0;
    endtask

    task automatic send_cmd(input int sx, input int sy, input int tx, input int ty);
        cmd_valid    = 1'b1;
        cmd_spawn_x  = 11'(sx);
        cmd_spawn_y  = 10'(sy);
        cmd_target_x = 11'(tx);
        cmd_target_y = 10'(ty);
        tick("cmd");
        cmd_valid = 1'b0;
    endtask

    task automatic retire();
        kill = 1'b1;
        new_frame = 1'b1;
        tick("retire");
        kill = 1'b0;
        new_frame = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0; new_frame = 1'b0; cmd_valid = 1'b0; kill = 1'b0;
        cmd_spawn_x = '0; cmd_spawn_y = '0; cmd_target_x = '0; cmd_target_y = '0;
        model_reset();
        repeat (2) tick("rst");
        chk("rst.valid_c", sprite_valid, 0);
        chk("rst.ready_c", cmd_ready, 1);
        chk("rst.frame_c", sprite_frame_number, 0);
        sys_rst_n = 1'b1;
        tick("idle");

        // Walk and arrive: (100,200) -> (106,200)
        send_cmd(100, 200, 106, 200);
        chk("walk.ready_low", cmd_ready, 0);
        tick("armed");
        chk("walk.armed_invalid", sprite_valid, 0);
        pulse_nf("walk");
        chk("walk.x0", sprite_x, 100);
        chk("walk.v0", sprite_valid, 1);
        chk("walk.f0", sprite_frame_number, 0);
        tick("walk");
        pulse_nf("walk");
        chk("walk.x1", sprite_x, 102);
        pulse_nf("walk");
        chk("walk.x2", sprite_x, 104);
        pulse_nf("walk");
        chk("walk.x3", sprite_x, 106);
        chk("walk.arrived", arrived, 1);
        chk("walk.f12", sprite_frame_number, 12);
        tick("walk");
        chk("walk.arrived_once", arrived, 0);

        // Attack animation loops 12..22 -> 12
        repeat (40) pulse_nf("atk");
        chk("atk.f22", sprite_frame_number, 22);
        repeat (4) pulse_nf("atk");
        chk("atk.wrap12", sprite_frame_number, 12);

        // Kill mid-frame: stays visible until the next new_frame
        kill = 1'b1;
        tick("kill");
        kill = 1'b0;
        chk("kill.still_valid", sprite_valid, 1);
        repeat (3) tick("kill");
        chk("kill.still_valid2", sprite_valid, 1);
        pulse_nf("kill");
        chk("kill.invalid", sprite_valid, 0);
        chk("kill.ready", cmd_ready, 1);

        // Diagonal with overshoot clamp
        send_cmd(10, 10, 13, 15);
        pulse_nf("diag");
        chk("diag.p0", sprite_x * 1000 + sprite_y, 10010);
        pulse_nf("diag");
        chk("diag.p1", sprite_x * 1000 + sprite_y, 12012);
        pulse_nf("diag");
        chk("diag.p2", sprite_x * 1000 + sprite_y, 13014);
        pulse_nf("diag");
        chk("diag.p3", sprite_x * 1000 + sprite_y, 13015);
        chk("diag.arrived", arrived, 1);

        // Kill coincident with new_frame retires on that edge
        retire();
        chk("killnf.invalid", sprite_valid, 0);
        chk("killnf.ready", cmd_ready, 1);

        // Walk animation wraps 11 -> 0
        send_cmd(0, 0, 1000, 0);
        pulse_nf("wwrap");
        repeat (44) pulse_nf("wwrap");
        chk("wwrap.f11", sprite_frame_number, 11);
        repeat (4) pulse_nf("wwrap");
        chk("wwrap.f0", sprite_frame_number, 0);

        // Backpressure: command held during WALK waits for IDLE
        cmd_valid = 1'b1;
        cmd_spawn_x = 11'd1276; cmd_spawn_y = 10'd716;
        cmd_target_x = 11'd2000; cmd_target_y = 10'd900;
        repeat (5) tick("bp");
        chk("bp.ready_low", cmd_ready, 0);
        kill = 1'b1;
        tick("bp");
        kill = 1'b0;
        pulse_nf("bp");
        chk("bp.ready_high", cmd_ready, 1);
        tick("bp");
        cmd_valid = 1'b0;
        chk("bp.accepted", cmd_ready, 0);
        pulse_nf("clamp");
        pulse_nf("clamp");
        pulse_nf("clamp");
        chk("clamp.x", sprite_x, 1279);
        chk("clamp.y", sprite_y, 719);
        chk("clamp.arrived", arrived, 1);
        retire();

        // Kill while ARMED drops the command immediately
        send_cmd(5, 5, 50, 50);
        kill = 1'b1;
        tick("karm");
        kill = 1'b0;
        chk("karm.ready", cmd_ready, 1);
        chk("karm.valid", sprite_valid, 0);

        // Asynchronous reset mid-walk
        send_cmd(300, 300, 900, 600);
        repeat (3) pulse_nf("rstw");
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("arst.valid", sprite_valid, 0);
        chk("arst.x", sprite_x, 0);
        chk("arst.y", sprite_y, 0);
        chk("arst.frame", sprite_frame_number, 0);
        chk("arst.ready", cmd_ready, 1);
        model_reset();
        tick("arst");
        sys_rst_n = 1'b1;
        tick("arst");
        chk("arst.ready_after", cmd_ready, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int sx, sy;
            sx = int'($urandom_range(0, 2047));
            sy = int'($urandom_range(0, 1023));
            new_frame = ($urandom_range(0, 3) == 0);
            kill      = ($urandom_range(0, 60) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_spawn_x = 11'(sx);
            cmd_spawn_y = 10'(sy);
            case ($urandom_range(0, 7))
                0: begin
                    cmd_target_x = 11'(sx);
                    cmd_target_y = 10'(sy);
                end
                1: begin
                    cmd_target_x = 11'($urandom_range(0, 2047));
                    cmd_target_y = 10'($urandom_range(0, 1023));
                end
                default: begin
                    cmd_target_x = 11'(sx + int'($urandom_range(0, 40)) - 20);
                    cmd_target_y = 10'(sy + int'($urandom_range(0, 40)) - 20);
                end
            endcase
            tick("rand");
        end
        new_frame = 1'b0; kill = 1'b0; cmd_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
